// File: rtl/zz_rlc.sv
`default_nettype none
// ============================================================================
// Module      : zz_rlc
// Description : JPEG run-length coder. Takes one 8x8 block of zigzag-ordered
//               quantized coefficients and emits a DC difference followed by
//               AC run/amplitude symbols (with ZRL and EOB) for the packer.
// Revision    : 1.0 - initial release
// ============================================================================
module zz_rlc #(
    parameter int COEF_W = 12,
    parameter int NCOMP  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    input  logic [1:0]        in_comp,
    input  logic              stall,
    output logic              DC_valid,
    output logic [15:0]       data_dc,
    output logic              valid,
    output logic [15:0]       data_ac,
    output logic              last,
    output logic              block_done
);

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_ZRL    = 1'b1
    } state_t;

    localparam logic signed [COEF_W-1:0] c_amp_max = COEF_W'(127);
    localparam logic signed [COEF_W-1:0] c_amp_min = COEF_W'(-128);
    localparam logic [15:0]              c_zrl     = 16'hF000;

    state_t              r_state,    w_state;
    logic [5:0]          r_idx,      w_idx;
    logic [5:0]          r_run,      w_run;
    logic [7:0]          r_pend_amp, w_pend_amp;
    logic                r_pend_last, w_pend_last;
    logic [COEF_W-1:0]   r_pred [NCOMP];
    logic [COEF_W-1:0]   w_pred [NCOMP];
    logic                r_dc_valid, w_dc_valid;
    logic [15:0]         r_data_dc,  w_data_dc;
    logic                r_valid,    w_valid;
    logic [15:0]         r_data_ac,  w_data_ac;
    logic                r_last,     w_last;
    logic                r_done,     w_done;

    logic                w_accept;
    logic [1:0]          w_comp;
    logic [COEF_W-1:0]   w_pred_sel;
    logic [COEF_W:0]     w_diff;
    logic [7:0]          w_amp;
    logic                w_zero;
    logic                w_idx_last;

    assign in_ready   = (r_state == ST_ACCEPT) & ~stall & ~rst & ~frame_start;
    assign w_accept   = in_valid & in_ready;
    assign w_zero     = (in_coef == '0);
    assign w_idx_last = (r_idx == 6'd63);

    assign DC_valid   = r_dc_valid;
    assign data_dc    = r_data_dc;
    assign valid      = r_valid;
    assign data_ac    = r_data_ac;
    assign last       = r_last;
    assign block_done = r_done;

    // Predictor select and DC difference at COEF_W+1 bits so it cannot overflow.
    always_comb begin
        w_comp = (32'(in_comp) < NCOMP) ? in_comp : 2'd0;
        w_pred_sel = '0;
        for (int i = 0; i < NCOMP; i++) begin
            if (w_comp == 2'(i)) begin
                w_pred_sel = r_pred[i];
            end
        end
        w_diff = {in_coef[COEF_W-1], in_coef} - {w_pred_sel[COEF_W-1], w_pred_sel};
    end

    // Amplitude saturation to the signed 8-bit range carried in data_ac.
    always_comb begin
        w_amp = in_coef[7:0];
        if ($signed(in_coef) > c_amp_max) begin
            w_amp = 8'h7F;
        end else if ($signed(in_coef) < c_amp_min) begin
            w_amp = 8'h80;
        end
    end

    // Next-state and next-output logic for the accept / ZRL-drain machine.
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_run       = r_run;
        w_pend_amp  = r_pend_amp;
        w_pend_last = r_pend_last;
        for (int i = 0; i < NCOMP; i++) begin
            w_pred[i] = r_pred[i];
        end
        w_dc_valid  = 1'b0;
        w_data_dc   = r_data_dc;
        w_valid     = 1'b0;
        w_data_ac   = r_data_ac;
        w_last      = 1'b0;
        w_done      = 1'b0;

        if (frame_start) begin
            w_state     = ST_ACCEPT;
            w_idx       = 6'd0;
            w_run       = 6'd0;
            w_pend_amp  = 8'd0;
            w_pend_last = 1'b0;
            for (int i = 0; i < NCOMP; i++) begin
                w_pred[i] = '0;
            end
        end else if (w_accept) begin
            w_idx = r_idx + 6'd1;
            if (r_idx == 6'd0) begin
                w_dc_valid = 1'b1;
                w_data_dc  = {{(15-COEF_W){w_diff[COEF_W]}}, w_diff};
                w_run      = 6'd0;
                for (int i = 0; i < NCOMP; i++) begin
                    if (w_comp == 2'(i)) begin
                        w_pred[i] = in_coef;
                    end
                end
            end else if (w_zero) begin
                if (w_idx_last) begin
                    // Trailing zeros collapse into EOB; no ZRLs are emitted.
                    w_valid   = 1'b1;
                    w_data_ac = 16'h0000;
                    w_last    = 1'b1;
                    w_done    = 1'b1;
                    w_run     = 6'd0;
                end else begin
                    w_run = r_run + 6'd1;
                end
            end else if (r_run < 6'd16) begin
                w_valid   = 1'b1;
                w_data_ac = {r_run[3:0], 4'h0, w_amp};
                w_last    = w_idx_last;
                w_done    = w_idx_last;
                w_run     = 6'd0;
            end else begin
                // First ZRL goes out immediately; the rest drain in ST_ZRL.
                w_valid     = 1'b1;
                w_data_ac   = c_zrl;
                w_run       = r_run - 6'd16;
                w_pend_amp  = w_amp;
                w_pend_last = w_idx_last;
                w_state     = ST_ZRL;
            end
        end else if ((r_state == ST_ZRL) && !stall) begin
            w_valid = 1'b1;
            if (r_run >= 6'd16) begin
                w_data_ac = c_zrl;
                w_run     = r_run - 6'd16;
            end else begin
                w_data_ac   = {r_run[3:0], 4'h0, r_pend_amp};
                w_last      = r_pend_last;
                w_done      = r_pend_last;
                w_run       = 6'd0;
                w_pend_last = 1'b0;
                w_state     = ST_ACCEPT;
            end
        end
    end

    // State, predictor and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCEPT;
            r_idx       <= 6'd0;
            r_run       <= 6'd0;
            r_pend_amp  <= 8'd0;
            r_pend_last <= 1'b0;
            for (int i = 0; i < NCOMP; i++) begin
                r_pred[i] <= '0;
            end
            r_dc_valid  <= 1'b0;
            r_data_dc   <= 16'd0;
            r_valid     <= 1'b0;
            r_data_ac   <= 16'd0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_run       <= w_run;
            r_pend_amp  <= w_pend_amp;
            r_pend_last <= w_pend_last;
            for (int i = 0; i < NCOMP; i++) begin
                r_pred[i] <= w_pred[i];
            end
            r_dc_valid  <= w_dc_valid;
            r_data_dc   <= w_data_dc;
            r_valid     <= w_valid;
            r_data_ac   <= w_data_ac;
            r_last      <= w_last;
            r_done      <= w_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zz_rlc.sv
`default_nettype none
// ============================================================================
// Module      : tb_zz_rlc
// Description : Directed self-checking bench for the zz_rlc run-length coder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zz_rlc;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_coef;
    logic [1:0]  in_comp;
    logic        stall;
    logic        DC_valid;
    logic [15:0] data_dc;
    logic        valid;
    logic [15:0] data_ac;
    logic        last;
    logic        block_done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] dc_q [$];
    logic [16:0] ac_q [$];
    logic [11:0] blk [64];
    int          rdy_low;
    int          proto_err;

    zz_rlc #(.COEF_W(12), .NCOMP(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coef    (in_coef),
        .in_comp    (in_comp),
        .stall      (stall),
        .DC_valid   (DC_valid),
        .data_dc    (data_dc),
        .valid      (valid),
        .data_ac    (data_ac),
        .last       (last),
        .block_done (block_done)
    );

    always #5 clk = ~clk;

    // Log strobes and protocol observations mid-cycle, after stimulus settles.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (DC_valid) dc_q.push_back(data_dc);
            if (valid) ac_q.push_back({last, data_ac});
            if ((block_done !== (valid & last)) || (last && !valid) || (DC_valid && valid))
                proto_err++;
            if (in_valid && !in_ready) rdy_low++;
        end
    end

    task automatic send(input logic [11:0] c, input logic [1:0] comp);
        int n = 0;
        in_valid = 1'b1;
        in_coef  = c;
        in_comp  = comp;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 12'h000;
    endtask

    task automatic send_block(input logic [1:0] comp);
        for (int i = 0; i < 64; i++) send(blk[i], comp);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, DC_valid, valid, last, block_done, data_dc, data_ac} !== 37'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b dcv=%b v=%b last=%b bd=%b dc=%h ac=%h, required all 0",
                     in_ready, DC_valid, valid, last, block_done, data_dc, data_ac);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_frame_start();
        frame_start = 1'b1;
        in_valid    = 1'b1;
        in_coef     = 12'h123;
        in_comp     = 2'd0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fs_ready: in_ready=%b, required 0", in_ready);
        end
        @(negedge clk);
        frame_start = 1'b0;
        in_valid    = 1'b0;
        checks++;
        if (DC_valid !== 1'b0) begin
            failures++;
            $display("FAIL fs_no_accept: DC_valid=%b, required 0", DC_valid);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [16:0] eac [$];
        bit ok;
        frame_pulse();
        dc_q.delete(); ac_q.delete();
        send(12'h7FF, 2'd0);
        checks++;
        if (DC_valid !== 1'b1 || data_dc !== 16'h07FF || valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_dc: DC_valid=%b data_dc=%h valid=%b, required 1 07ff 0", DC_valid, data_dc, valid);
        end
        send(12'h070, 2'd0);
        for (int i = 2; i < 64; i++) send(12'h000, 2'd0);
        checks++;
        if (valid !== 1'b1 || last !== 1'b1 || block_done !== 1'b1 || data_ac !== 16'h0000) begin
            failures++;
            $display("FAIL basic_eob: valid=%b last=%b bd=%b data_ac=%h, required 1 1 1 0000",
                     valid, last, block_done, data_ac);
        end
        drain();
        eac = '{17'h00070, 17'h10000};
        checks++;
        ok = (ac_q.size() == eac.size()) && (dc_q.size() == 1);
        for (int i = 0; ok && i < eac.size(); i++) ok = (ac_q[i] === eac[i]);
        if (!ok) begin
            failures++;
            $display("FAIL basic_seq: got ac n=%0d dc n=%0d first ac %h, required ac n=2 dc n=1 first ac 00070",
                     ac_q.size(), dc_q.size(), ac_q[0]);
        end
    endtask

    task automatic test_zrl();
        logic [16:0] eac [$];
        bit ok;
        frame_pulse();
        dc_q.delete(); ac_q.delete();
        clear_blk();
        blk[18] = 12'h0CC;
        rdy_low = 0;
        send_block(2'd0);
        drain();
        // 0x0CC = 204 lies above the 8-bit amplitude range, so it saturates to 0x7F.
        eac = '{17'h0F000, 17'h0107F, 17'h10000};
        checks++;
        ok = (ac_q.size() == eac.size());
        for (int i = 0; ok && i < eac.size(); i++) ok = (ac_q[i] === eac[i]);
        if (!ok) begin
            failures++;
            $display("FAIL zrl_seq: got n=%0d [%h %h], required n=3 [0f000 0107f]", ac_q.size(), ac_q[0], ac_q[1]);
        end
        checks++;
        if (rdy_low != 1) begin
            failures++;
            $display("FAIL zrl_ready_low: got %0d cycles, required 1", rdy_low);
        end
    endtask

    task automatic test_eob63();
        logic [16:0] eac [$];
        bit ok;
        frame_pulse();
        dc_q.delete(); ac_q.delete();
        proto_err = 0;
        clear_blk();
        blk[63] = 12'h011;
        send_block(2'd0);
        drain();
        eac = '{17'h0F000, 17'h0F000, 17'h0F000, 17'h1E011};
        checks++;
        ok = (ac_q.size() == eac.size());
        for (int i = 0; ok && i < eac.size(); i++) ok = (ac_q[i] === eac[i]);
        if (!ok) begin
            failures++;
            $display("FAIL eob63_seq: got n=%0d last %h, required n=4 last 1e011", ac_q.size(), ac_q[$]);
        end
        checks++;
        if (proto_err != 0) begin
            failures++;
            $display("FAIL eob63_block_done: got %0d protocol violations, required 0", proto_err);
        end
    endtask

    task automatic test_dc_pred();
        logic [15:0] edc [$];
        bit ok;
        frame_pulse();
        dc_q.delete(); ac_q.delete();
        clear_blk();
        blk[0] = 12'd100; send_block(2'd0);
        blk[0] = 12'd90;  send_block(2'd0);
        blk[0] = 12'd5;   send_block(2'd1);
        drain();
        edc = '{16'h0064, 16'hFFF6, 16'h0005};
        checks++;
        ok = (dc_q.size() == edc.size());
        for (int i = 0; ok && i < edc.size(); i++) ok = (dc_q[i] === edc[i]);
        if (!ok) begin
            failures++;
            $display("FAIL dc_pred_seq: got n=%0d [%h %h %h], required [0064 fff6 0005]",
                     dc_q.size(), dc_q[0], dc_q[1], dc_q[2]);
        end
        frame_pulse();
        dc_q.delete();
        blk[0] = 12'd90; send_block(2'd0);
        // Component 3 is out of range and shares predictor 0 (now 90): 10-90 = -80.
        blk[0] = 12'd10; send_block(2'd3);
        drain();
        edc = '{16'h005A, 16'hFFB0};
        checks++;
        ok = (dc_q.size() == edc.size());
        for (int i = 0; ok && i < edc.size(); i++) ok = (dc_q[i] === edc[i]);
        if (!ok) begin
            failures++;
            $display("FAIL dc_after_fs: got n=%0d [%h %h], required [005a ffb0]", dc_q.size(), dc_q[0], dc_q[1]);
        end
    endtask

    task automatic test_saturation();
        logic [16:0] eac [$];
        bit ok;
        frame_pulse();
        dc_q.delete(); ac_q.delete();
        clear_blk();
        blk[1] = 12'h12C;   // +300
        blk[2] = 12'hED4;   // -300
        send_block(2'd0);
        drain();
        eac = '{17'h0007F, 17'h00080, 17'h10000};
        checks++;
        ok = (ac_q.size() == eac.size());
        for (int i = 0; ok && i < eac.size(); i++) ok = (ac_q[i] === eac[i]);
        if (!ok) begin
            failures++;
            $display("FAIL sat_seq: got n=%0d [%h %h], required [0007f 00080]", ac_q.size(), ac_q[0], ac_q[1]);
        end
    endtask

    task automatic test_stall();
        logic [16:0] eac [$];
        bit ok;
        frame_pulse();
        dc_q.delete(); ac_q.delete();
        clear_blk();
        for (int i = 0; i < 63; i++) send(blk[i], 2'd0);
        send(12'h011, 2'd0);
        // First ZRL is already on the outputs; freeze the rest.
        stall = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #2;
            checks++;
            if (valid !== 1'b0 || DC_valid !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b DC_valid=%b in_ready=%b, required 0 0 0",
                         c, valid, DC_valid, in_ready);
            end
        end
        stall = 1'b0;
        drain();
        eac = '{17'h0F000, 17'h0F000, 17'h0F000, 17'h1E011};
        checks++;
        ok = (ac_q.size() == eac.size());
        for (int i = 0; ok && i < eac.size(); i++) ok = (ac_q[i] === eac[i]);
        if (!ok) begin
            failures++;
            $display("FAIL stall_zrl_count: got n=%0d last %h, required n=4 last 1e011", ac_q.size(), ac_q[$]);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [16:0] eac [$];
        bit ok;
        frame_pulse();
        clear_blk();
        blk[0] = 12'd50;
        send_block(2'd0);
        drain();
        send(12'd20, 2'd0);
        send(12'h003, 2'd0);
        send(12'h000, 2'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dc_q.delete(); ac_q.delete();
        clear_blk();
        blk[0] = 12'd7;
        blk[1] = 12'h005;
        send_block(2'd0);
        drain();
        checks++;
        if (dc_q.size() != 1 || dc_q[0] !== 16'h0007) begin
            failures++;
            $display("FAIL rst_mid_dc: got n=%0d dc %h, required n=1 dc 0007", dc_q.size(), dc_q[0]);
        end
        eac = '{17'h00005, 17'h10000};
        checks++;
        ok = (ac_q.size() == eac.size());
        for (int i = 0; ok && i < eac.size(); i++) ok = (ac_q[i] === eac[i]);
        if (!ok) begin
            failures++;
            $display("FAIL rst_mid_idx: got n=%0d [%h %h], required [00005 10000]", ac_q.size(), ac_q[0], ac_q[1]);
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0;
        in_coef = 12'h000; in_comp = 2'd0; stall = 1'b0;
        rdy_low = 0; proto_err = 0;
        @(negedge clk);
        test_reset();
        test_frame_start();
        test_basic();
        test_zrl();
        test_eob63();
        test_dc_pred();
        test_saturation();
        test_stall();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
